// File: rtl/tx_pkg.sv
// Shared encodings for the serial transmit controller: mux selects, FSM states,
// and the parity helper used when a frame is latched.
package tx_pkg;

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_DATA   = 2'b01;
   localparam logic [1:0] SEL_PARITY = 2'b10;
   localparam logic [1:0] SEL_STOP   = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   function automatic logic [1:0] sel_of(input tx_state_e s);
      case (s)
         START:   return SEL_START;
         DATA:    return SEL_DATA;
         PARITY:  return SEL_PARITY;
         default: return SEL_STOP;
      endcase
   endfunction

   // Odd parity is the complement of the even (XOR-reduce) parity.
   function automatic logic parity_of(input logic [7:0] d, input logic odd);
      return odd ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/Tx_Baud_Gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each period (bit_tick) and the cycle before it (pre_tick).
module Tx_Baud_Gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic bit_tick_o,
   output logic pre_tick_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bit_tick_o = en_i && (cnt_q == CNT_LAST);
   // pre_tick lets registered outputs line up with the final cycle of a period.
   assign pre_tick_o = en_i && (cnt_q == CNT_PRE);

endmodule

// File: rtl/tx_controller.sv
// Serial frame sequencer: drives the TX mux select, data and parity bits for
// start / 8 data (LSB first) / optional parity / stop framing.
//
//   state  | meaning
//   IDLE   | line idle (select 11), waiting for Tx_start
//   START  | start bit (select 00)
//   DATA   | 8 data bits, LSB first (select 01)
//   PARITY | parity bit (select 10), only when PARITY_EN
//   STOP   | stop bit (select 11), Tx_done on its last cycle
module tx_controller
   import tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Tx_start,
   input  logic [7:0] Data_in,
   input  logic       Parity_odd,
   output logic [1:0] select,
   output logic       Data_bit,
   output logic       Parity_bit,
   output logic       Tx_busy,
   output logic       Tx_done
);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       parity_q, parity_d;
   logic [1:0] sel_q, sel_d;
   logic       data_bit_q, data_bit_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       armed_q;
   logic       bit_tick, pre_tick;

   Tx_Baud_Gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (state_q == IDLE),
      .en_i       (state_q != IDLE),
      .bit_tick_o (bit_tick),
      .pre_tick_o (pre_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // armed_q blocks a start on the very first edge after reset release.
            if (Tx_start && armed_q) begin
               state_d   = START;
               shift_d   = Data_in;
               bit_cnt_d = 3'd0;
               parity_d  = parity_of(Data_in, Parity_odd);
            end
         end
         START: if (bit_tick) state_d = DATA;
         DATA: begin
            if (bit_tick) begin
               shift_d   = {1'b1, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: if (bit_tick) state_d = STOP;
         STOP: begin
            done_d = pre_tick;
            if (bit_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      sel_d      = sel_of(state_d);
      data_bit_d = (state_d == DATA) ? shift_d[0] : 1'b1;
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         parity_q   <= 1'b0;
         sel_q      <= SEL_STOP;
         data_bit_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         parity_q   <= parity_d;
         sel_q      <= sel_d;
         data_bit_q <= data_bit_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         armed_q    <= 1'b1;
      end
   end

   assign select     = sel_q;
   assign Data_bit   = data_bit_q;
   assign Parity_bit = parity_q;
   assign Tx_busy    = busy_q;
   assign Tx_done    = done_q;

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: stimulus pushes expected frames into per-instance
// queues; a monitor tracks each frame cycle by cycle and scores it at frame end.
module tb_tx_controller;

   localparam int NB = 4;

   typedef struct {
      logic [7:0] data;
      logic       odd;
      bit         gap_chk;
      bit         aborted;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       odd_a = 1'b0, odd_b = 1'b0;
   logic [1:0] sel_a, sel_b;
   logic       dbit_a, dbit_b, pbit_a, pbit_b, busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_controller #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .Tx_start(start_a), .Data_in(data_a),
      .Parity_odd(odd_a), .select(sel_a), .Data_bit(dbit_a),
      .Parity_bit(pbit_a), .Tx_busy(busy_a), .Tx_done(done_a));

   tx_controller #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .Tx_start(start_b), .Data_in(data_b),
      .Parity_odd(odd_b), .select(sel_b), .Data_bit(dbit_b),
      .Parity_bit(pbit_b), .Tx_busy(busy_b), .Tx_done(done_b));

   logic [1:0] busy_v, done_v, dbit_v, pbit_v;
   logic [1:0] sel_v [2];
   assign busy_v = {busy_b, busy_a};
   assign done_v = {done_b, done_a};
   assign dbit_v = {dbit_b, dbit_a};
   assign pbit_v = {pbit_b, pbit_a};
   assign sel_v[0] = sel_a;
   assign sel_v[1] = sel_b;

   exp_t q_a[$];
   exp_t q_b[$];

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Reference timing of a frame, cycle k counted from 1 at the first busy cycle.
   function automatic void exp_at(input int k, input logic [7:0] d, input bit pen,
                                  output logic [1:0] s, output logic db);
      int bi;
      s = 2'b11; db = 1'b1;
      if (k <= NB) begin
         s = 2'b00;
      end else if (k <= 9 * NB) begin
         s  = 2'b01;
         bi = (k - NB - 1) / NB;
         db = d[bi];
      end else if (pen && k <= 10 * NB) begin
         s = 2'b10;
      end
   endfunction

   exp_t cur [2];
   bit   active [2];
   bit   prev_b [2];
   int   idx [2], idle [2], bad_sel [2], bad_db [2], bad_par [2], done_cnt [2], done_at [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         active[i] = 0; prev_b[i] = 0; idx[i] = 0; idle[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [1:0] es;
         logic       edb;
         bit         pen;
         int         flen;
         pen  = (i == 0);
         flen = pen ? 11 * NB : 10 * NB;
         if (busy_v[i] && !prev_b[i]) begin
            if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
               chk($sformatf("unexpected_frame_%0d", i), 1, 0);
               active[i] = 0;
            end else begin
               if (i == 0) cur[i] = q_a.pop_front();
               else        cur[i] = q_b.pop_front();
               active[i] = 1;
               if (cur[i].gap_chk) chk($sformatf("idle_gap_%0d", i), idle[i], 1);
            end
            idx[i] = 0; bad_sel[i] = 0; bad_db[i] = 0; bad_par[i] = 0;
            done_cnt[i] = 0; done_at[i] = 0;
         end
         if (busy_v[i]) begin
            idx[i]++;
            exp_at(idx[i], cur[i].data, pen, es, edb);
            if (sel_v[i] !== es) bad_sel[i]++;
            if (dbit_v[i] !== edb) bad_db[i]++;
            if (pbit_v[i] !== ((^cur[i].data) ^ cur[i].odd)) bad_par[i]++;
            if (done_v[i]) begin
               done_cnt[i]++;
               done_at[i] = idx[i];
            end
         end else begin
            idle[i]++;
         end
         if (!busy_v[i] && prev_b[i] && active[i]) begin
            if (cur[i].aborted) begin
               chk($sformatf("abort_nodone_%0d", i), done_cnt[i], 0);
            end else begin
               chk($sformatf("sel_seq_%0d_%h", i, cur[i].data), bad_sel[i], 0);
               chk($sformatf("data_bits_%0d_%h", i, cur[i].data), bad_db[i], 0);
               chk($sformatf("parity_%0d_%h", i, cur[i].data), bad_par[i], 0);
               chk($sformatf("frame_len_%0d_%h", i, cur[i].data), idx[i], flen);
               chk($sformatf("done_cnt_%0d_%h", i, cur[i].data), done_cnt[i], 1);
               chk($sformatf("done_cycle_%0d_%h", i, cur[i].data), done_at[i], flen);
            end
            active[i] = 0;
         end
         if (busy_v[i] && !prev_b[i]) idle[i] = 0;
         prev_b[i] = busy_v[i];
      end
   end

   task automatic push(input int i, input logic [7:0] d, input logic odd,
                       input bit gap, input bit ab);
      exp_t e;
      e.data = d; e.odd = odd; e.gap_chk = gap; e.aborted = ab;
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic wait_busy(input int i, input logic val, input string nm);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy_v[i] !== val && n < 300);
      if (busy_v[i] !== val) chk({nm, "_timeout"}, int'(busy_v[i]), int'(val));
   endtask

   task automatic wait_done(input int i, input string nm);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (done_v[i] !== 1'b1 && n < 300);
      if (done_v[i] !== 1'b1) chk({nm, "_timeout"}, int'(done_v[i]), 1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_select", int'(sel_a), 3);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_data_bit", int'(dbit_a), 1);
      chk("rst_parity", int'(pbit_a), 0);
      chk("rst_done", int'(done_a), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // A: 0xA5 even parity; B: 0x3C without parity phase, both from one pulse.
      push(0, 8'hA5, 1'b0, 0, 0);
      push(1, 8'h3C, 1'b0, 0, 0);
      data_a = 8'hA5; odd_a = 1'b0; start_a = 1'b1;
      data_b = 8'h3C; odd_b = 1'b0; start_b = 1'b1;
      wait_busy(0, 1'b1, "start_a1");
      start_a = 1'b0; start_b = 1'b0;
      wait_done(1, "done_b1");
      wait_done(0, "done_a1");
      wait_busy(0, 1'b0, "end_a1");
      repeat (3) @(posedge clk);
      #1;

      // Same byte, odd parity.
      push(0, 8'hA5, 1'b1, 0, 0);
      data_a = 8'hA5; odd_a = 1'b1; start_a = 1'b1;
      wait_busy(0, 1'b1, "start_a2");
      start_a = 1'b0;
      wait_done(0, "done_a2");
      wait_busy(0, 1'b0, "end_a2");
      repeat (3) @(posedge clk);
      #1;

      // Tx_start held high: back-to-back frames, inputs disturbed mid-frame.
      push(0, 8'h96, 1'b0, 0, 0);
      push(0, 8'h0F, 1'b0, 1, 0);
      push(0, 8'hC3, 1'b0, 1, 0);
      data_a = 8'h96; odd_a = 1'b0; start_a = 1'b1;
      wait_busy(0, 1'b1, "start_c1");
      data_a = 8'hFF; odd_a = 1'b1;
      repeat (20) @(posedge clk);
      #1 data_a = 8'h0F; odd_a = 1'b0;
      wait_done(0, "done_c1");
      wait_busy(0, 1'b0, "end_c1");
      wait_busy(0, 1'b1, "start_c2");
      data_a = 8'h00; odd_a = 1'b1;
      repeat (20) @(posedge clk);
      #1 data_a = 8'hC3; odd_a = 1'b0;
      wait_done(0, "done_c2");
      wait_busy(0, 1'b0, "end_c2");
      wait_busy(0, 1'b1, "start_c3");
      start_a = 1'b0; data_a = 8'h55; odd_a = 1'b1;
      wait_done(0, "done_c3");
      wait_busy(0, 1'b0, "end_c3");
      repeat (3) @(posedge clk);
      #1;

      // Reset during DATA bit 3 (cycle 18), then a clean frame after release.
      push(0, 8'hF0, 1'b1, 0, 1);
      data_a = 8'hF0; odd_a = 1'b1; start_a = 1'b1;
      wait_busy(0, 1'b1, "start_r1");
      start_a = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("pre_rst_select", int'(sel_a), 1);
      chk("pre_rst_parity", int'(pbit_a), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_select", int'(sel_a), 3);
      chk("mid_rst_busy", int'(busy_a), 0);
      chk("mid_rst_data_bit", int'(dbit_a), 1);
      chk("mid_rst_parity", int'(pbit_a), 0);
      push(0, 8'h5A, 1'b0, 0, 0);
      data_a = 8'h5A; odd_a = 1'b0; start_a = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arm_delay_busy", int'(busy_a), 0);
      wait_busy(0, 1'b1, "start_r2");
      start_a = 1'b0;
      wait_done(0, "done_r2");
      wait_busy(0, 1'b0, "end_r2");
      repeat (4) @(posedge clk);
      #1;

      chk("queue_a_left", q_a.size(), 0);
      chk("queue_b_left", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
